// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its lane aligner.
package dmem_arbiter_pkg;

    localparam int DMEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } dmem_arb_state_e;

    typedef union packed {
        logic [31:0]      w;
        logic [1:0][15:0] h;
        logic [3:0][7:0]  b;
    } dataBus_u;

    // True when the byte offset is a legal start position for the access size.
    function automatic logic size_aligned(mem_size_e size, logic [1:0] offset);
        case (size)
            BYTE:    size_aligned = 1'b1;
            HALF:    size_aligned = ~offset[0];
            WORD:    size_aligned = (offset == 2'b00);
            default: size_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_lane_align.sv
// Combinational lane handling: extracts a zero-extended load lane from a memory
// word and merges right-aligned store data into a word for sub-word writes.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] lane_data,
    output logic [31:0] merged
);

    dataBus_u word_u;
    dataBus_u data_u;
    dataBus_u merged_u;

    always_comb begin
        word_u    = word;
        data_u    = data;
        merged_u  = word;
        lane_data = '0;
        case (size)
            BYTE: begin
                lane_data          = {24'd0, word_u.b[offset]};
                merged_u.b[offset] = data_u.b[0];
            end
            HALF: begin
                lane_data             = {16'd0, word_u.h[offset[1]]};
                merged_u.h[offset[1]] = data_u.h[0];
            end
            default: begin
                lane_data  = word_u.w;
                merged_u.w = data_u.w;
            end
        endcase
        merged = merged_u.w;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer in front of the single-port word memory.
// Define DMEM_ARB_RMW_EN to allow sub-word stores via read-modify-write.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][1:0]        req_size,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    dmem_arb_state_e   state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    mem_size_e         size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       rmw_word_q, rmw_word_d;

    logic              grant;
    logic              accept;
    logic              req_err;
    mem_size_e         sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       lane_data;
    logic [31:0]       merged;

    dmem_lane_align u_lane_align (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .word      ((state_q == WRITE) ? rmw_word_q : mem_rdata),
        .data      (wdata_q),
        .lane_data (lane_data),
        .merged    (merged)
    );

    // Round-robin pick and accept-time validation of the winning request.
    always_comb begin
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
        accept   = (state_q == IDLE) && clk_en && (|req_valid);
        sel_size = mem_size_e'(req_size[grant]);
        sel_addr = req_addr[grant];
        req_err  = !size_aligned(sel_size, sel_addr[1:0]) || ((sel_addr >> 2) >= DEPTH_A);
`ifndef DMEM_ARB_RMW_EN
        req_err  = req_err || (req_we[grant] && (sel_size != WORD));
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rmw_word_d   = rmw_word_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    we_d         = req_we[grant];
                    size_d       = sel_size;
                    addr_d       = sel_addr;
                    wdata_d      = req_wdata[grant];
                    rdata_d      = '0;
                    if (req_err)
                        state_d = ERR;
                    else if (req_we[grant] && (sel_size == WORD))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                if (clk_en && mem_ready) begin
                    rdata_d    = lane_data;
                    rmw_word_d = mem_rdata;
                    state_d    = we_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                if (clk_en && mem_ready)
                    state_d = RESP;
            end
            RESP, ERR: begin
                if (clk_en)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rmw_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rmw_word_q   <= rmw_word_d;
        end
    end

    // req_ready is gated by rst_n so every output reads zero while in reset.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n)
            req_ready[grant] = 1'b1;
        rsp_valid = '0;
        if (((state_q == RESP) || (state_q == ERR)) && clk_en)
            rsp_valid[owner_q] = 1'b1;
        rsp_err   = (state_q == ERR) && clk_en;
        rsp_rdata = ((state_q == RESP) && clk_en && !we_q) ? rdata_q : '0;
        mem_rd_en = (state_q == READ);
        mem_wr_en = (state_q == WRITE);
        mem_addr  = (mem_rd_en || mem_wr_en) ? 32'(addr_q >> 2) : '0;
        mem_wdata = mem_wr_en ? merged : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequencer and two-port arbiter in front of the single-port, word-wide data memory.
- Requester 0 is the core load/store path; requester 1 is the debug/DMA path.
- Arbitrates round-robin, checks alignment and range, and drives the memory's read/write enables one access at a time.
- Converts byte and halfword accesses into word accesses, using read-modify-write for sub-word stores.

Parameters:
- DEPTH, 1024: memory depth in 32-bit words. Word index = addr[31:2].
- ADDR_W, 32: requester byte-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  clock enable; all state frozen while low
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept (one-hot or zero)
- req_we  in  2  1 = store, 0 = load
- req_size  in  2x2  00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  2xADDR_W  byte address
- req_wdata  in  2x32  store data, right-aligned
- rsp_valid  out  2  one-cycle response pulse to the owning requester
- rsp_rdata  out  32  load data, zero-extended, right-aligned; shared by both requesters
- rsp_err  out  1  qualifies rsp_valid: misaligned / out of range / illegal size
- mem_addr  out  32  word index to memory
- mem_wdata  out  32  write data to memory
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_rdata  in  32  memory read data (combinational)
- mem_ready  in  1  memory access done this cycle

Behaviour:
- Reset (rst_n low): state IDLE, last_grant=1, and every output 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_*.
- Reset asserted mid-operation abandons the access with no response.
- FSM states: IDLE, READ, WRITE, RESP, ERR.
- IDLE arbitration:
  - If any req_valid and clk_en, grant round-robin.
  - The requester not granted last time wins a tie.
  - A single valid requester always wins.
  - req_ready[g] is asserted combinationally in IDLE only; the request is latched (owner, we, size, addr, wdata) at the same edge, and last_grant=g.
- Error check at accept, before any memory access. An error goes to ERR.
  - size 11 is an error.
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - addr[31:2] >= DEPTH is out of range.
- ERR: one cycle, rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, then IDLE. No memory strobe is issued.
- Load:
  - READ asserts mem_rd_en with mem_addr=word index and holds until mem_ready.
  - On mem_ready, the selected lane is captured: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. The value is zero-extended.
  - Then RESP.
- Word store: WRITE asserts mem_wr_en, mem_wdata=wdata, holds until mem_ready, then RESP.
- Sub-word store (read-modify-write):
  - READ as for a load.
  - The lane is merged into the captured word, then WRITE with the merged word.
  - Then RESP.
- RESP: one cycle, rsp_valid[owner]=1, rsp_err=0. rsp_rdata holds load data (0 for stores). Then IDLE.
- No response back-pressure: the requester must accept a response in its rsp_valid cycle.
- Latency with mem_ready always 1, accept at edge T:
  - Word load or store: rsp_valid in cycle T+2.
  - Sub-word store: rsp_valid in cycle T+3.
  - Error: rsp_valid in cycle T+1.
- Throughput: at most one request accepted per IDLE visit.
  - Back-to-back requests from the same requester are separated by ≥1 idle cycle for the other requester's chance.
- mem_rd_en and mem_wr_en are never asserted together.
- clk_en low: no state change, req_ready=0, memory strobes held. rsp_valid pulses only on an enabled cycle.

Optional Feature:
- Macro: DMEM_ARB_RMW_EN.
- Defined: sub-word stores use read-modify-write as above.
- Undefined: sub-word stores are errors (ERR path), and READ is never entered for stores. Loads are unaffected.

Decomposition:
- Shared package additions:
  - mem_size_e enum (BYTE, HALF, WORD, ILLEGAL).
  - dmem_arb_state_e enum.
  - DMEM_DEPTH constant.
  - Reuse of the existing dataBus_u data type.
- One combinational sub-module, dmem_lane_align: lane extract (load) and lane merge (store) from size, addr[1:0], word and data.

Test Plan:
- Port 0 word load addr 0x10, memory word 4 = 0xDEADBEEF, mem_ready=1 → rsp_valid[0] at T+2, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Both ports valid every cycle with word loads → grants alternate 0,1,0,1. No requester is granted twice in a row while the other is waiting.
- Port 1 byte store 0xAB to addr 0x0000_0013, word 4 = 0x11223344 (DMEM_ARB_RMW_EN) → mem read then write of 0xAB223344, rsp_valid[1] at T+3. Without the macro → rsp_err=1 at T+1, no mem_wr_en.
- Half load addr 0x11 → rsp_err=1 at T+1, mem_rd_en never asserted. Word load addr 0x1000 (index 1024) → rsp_err=1.
- mem_ready low for 3 cycles during a load → mem_rd_en held and mem_addr stable; rsp_valid one cycle after mem_ready rises.
- rst_n pulsed low during WRITE → all outputs 0 immediately; after release, port 0 wins the first tie.
